// File: rtl/rns_pkg.sv
// ---------------------------------------------------------------------------
// rns_pkg
// Shared definitions for the RNS reconstruction unit:
//   - default moduli of the two residue domains and the mixed-radix inverse
//   - FSM state encoding of the reconstruction sequencer
//   - field positions of the packed 16-bit residue word
//   - small helper to pull one residue field out of the packed word
// No ports (package).
// ---------------------------------------------------------------------------
package rns_pkg;

    // Moduli are carried as 9-bit values so that 256 is representable.
    localparam int         RNS_MW      = 9;
    localparam logic [8:0] RNS_M0      = 9'd129;
    localparam logic [8:0] RNS_M1      = 9'd256;
    // M0^-1 mod M1: 129 * 129 = 16641 = 65 * 256 + 1.
    localparam logic [8:0] RNS_INV     = 9'd129;

    localparam int RNS_RES_WID   = 16;
    localparam int RNS_TAG_WID   = 4;

    // Packed residue word: {r1 [15:8], r0 [7:0]}.
    localparam int RNS_WORD_WID  = 16;
    localparam int RNS_FIELD_WID = 8;
    localparam int RNS_R0_LSB    = 0;
    localparam int RNS_R1_LSB    = 8;

    // Both serial loops walk a 9-bit operand from bit 8 down to bit 0.
    localparam logic [3:0] RNS_TOP_BIT = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_MODMUL = 3'd2,
        ST_RECON  = 3'd3,
        ST_DONE   = 3'd4
    } rns_state_e;

    function automatic logic [RNS_FIELD_WID-1:0] rns_field(
        input logic [RNS_WORD_WID-1:0] res_word,
        input int                      lsb
    );
        return res_word[lsb +: RNS_FIELD_WID];
    endfunction

endpackage

// File: rtl/rns_modmul_seq.sv
// ---------------------------------------------------------------------------
// rns_modmul_seq
// Bit-serial interleaved modular multiplier: result = a_in * b_in mod m_in.
// One multiplier bit per clock, MSB first, W steps after start.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-low reset
//   start   in   load operands and clear the accumulator (one-cycle pulse)
//   a_in    in   W-bit multiplicand, must be < m_in
//   b_in    in   W-bit multiplier
//   m_in    in   W-bit modulus (up to 2^(W-1))
//   done    out  high during the cycle whose edge performs the last step
//   result  out  accumulator; holds a*b mod m once the last step is taken
// ---------------------------------------------------------------------------
module rns_modmul_seq
    import rns_pkg::*;
#(
    parameter int W = RNS_MW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic [W-1:0] m_in,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Intermediate values of one interleaved step; W+1 bits so 2*(m-1)
    // and (m-1)+(m-1) both fit before the conditional subtract.
    logic [W:0]    dbl;
    logic [W:0]    m_ext;
    logic [W-1:0]  after_dbl;
    logic [W:0]    sum;
    logic [W-1:0]  after_add;

    // One step: double and reduce, then add the multiplicand and reduce
    // again if the current multiplier bit (kept at the MSB of b_q) is set.
    always_comb begin
        m_ext     = {1'b0, m_in};
        dbl       = {acc_q, 1'b0};
        after_dbl = (dbl >= m_ext) ? W'(dbl - m_ext) : W'(dbl);
        sum       = {1'b0, after_dbl} + {1'b0, a_q};
        after_add = (sum >= m_ext) ? W'(sum - m_ext) : W'(sum);
    end

    // Sequencing: start loads operands, then W steps shift b_q left so
    // the bit being consumed is always b_q[W-1].
    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            acc_d  = '0;
            a_d    = a_in;
            b_d    = b_in;
            cnt_d  = CW'(W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = b_q[W-1] ? after_add : after_dbl;
            b_d   = {b_q[W-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done   = busy_q && (cnt_q == '0);
    assign result = acc_q;

endmodule

// File: rtl/pl_rns_recon.sv
// ---------------------------------------------------------------------------
// pl_rns_recon
// RNS-to-integer reconstruction (inverse of the roll-modular encode).
// Converts a packed 2-domain residue pair {r1, r0} into x = r0 + M0*k with
// k = (r1 - r0) * M0^-1 mod M1, behind a valid/ready handshake.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   in_valid   in   residue pair offered
//   in_ready   out  unit idle, can accept
//   in_res     in   {r1 [15:8] domain 1, r0 [7:0] domain 0}
//   in_tag     in   destination register tag, returned with the result
//   out_valid  out  result available (held until out_ready)
//   out_ready  in   consumer takes the result
//   out_data   out  reconstructed integer
//   out_tag    out  tag captured at accept
//   out_err    out  residue out of range (r0 >= M0 or r1 >= M1)
//
// Build option: define RNS_RECON_FASTMUL_EN to replace the two 9-cycle
// serial loops with single-cycle combinational multiplies (3-clock
// latency, identical results). Default is the serial shift-add datapath.
// ---------------------------------------------------------------------------
module pl_rns_recon
    import rns_pkg::*;
#(
    parameter logic [8:0] M0      = RNS_M0,
    parameter logic [8:0] M1      = RNS_M1,
    parameter logic [8:0] INV     = RNS_INV,
    parameter int         RES_WID = RNS_RES_WID,
    parameter int         TAG_WID = RNS_TAG_WID
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RNS_WORD_WID-1:0] in_res,
    input  logic [TAG_WID-1:0]      in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RES_WID-1:0]      out_data,
    output logic [TAG_WID-1:0]      out_tag,
    output logic                    out_err
);

    generate
        if ((M0 > M1) || (RES_WID < $clog2(int'(M0) * int'(M1)))) begin : g_bad_cfg
            $error("pl_rns_recon: M0 must not exceed M1 and RES_WID must hold M0*M1-1");
        end
    endgenerate

    rns_state_e state_q, state_d;

    logic [RNS_FIELD_WID-1:0] r0_q, r0_d;
    logic [RNS_FIELD_WID-1:0] r1_q, r1_d;
    logic [TAG_WID-1:0]       tag_q, tag_d;
    logic                     err_q, err_d;
    logic [RES_WID-1:0]       out_data_q, out_data_d;

    logic                     range_err;
    logic [8:0]               d_val;
    logic [RES_WID-1:0]       r0_ext;

`ifdef RNS_RECON_FASTMUL_EN
    logic [8:0]               d_q, d_d;
    logic [8:0]               k_q, k_d;
    logic [17:0]              prod_fast;
    logic [17:0]              mod_fast;
    logic [RES_WID-1:0]       recon_fast;
`else
    logic [RES_WID-1:0]       x_q, x_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     mul_start;
    logic                     mul_done;
    logic [8:0]               mul_result;
    logic                     k_bit;
    logic [RES_WID-1:0]       x_next;
`endif

    // Range check and the first mixed-radix digit difference. Since both
    // residues are below M1, r1 - r0 needs at most one add of M1 to wrap.
    always_comb begin
        range_err = ({1'b0, r0_q} >= M0) || ({1'b0, r1_q} >= M1);
        if (r1_q >= r0_q) begin
            d_val = 9'(r1_q) - 9'(r0_q);
        end else begin
            d_val = 9'(r1_q) + M1 - 9'(r0_q);
        end
        r0_ext = RES_WID'(r0_q);
    end

`ifdef RNS_RECON_FASTMUL_EN
    // Single-cycle versions of the two loops.
    always_comb begin
        prod_fast  = 18'(d_q) * 18'(INV);
        mod_fast   = prod_fast % 18'(M1);
        recon_fast = RES_WID'(M0) * RES_WID'(k_q);
    end
`else
    // k = d * INV mod M1, one INV bit per clock.
    rns_modmul_seq #(
        .W (RNS_MW)
    ) u_modmul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a_in   (d_val),
        .b_in   (INV),
        .m_in   (M1),
        .done   (mul_done),
        .result (mul_result)
    );

    // Serial M0*k: shift x and add M0 for each set bit of k, MSB first.
    always_comb begin
        k_bit  = mul_result[cnt_q];
        x_next = (x_q << 1) + (k_bit ? RES_WID'(M0) : '0);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = range_err ? ST_DONE : ST_MODMUL;
            end
            ST_MODMUL: begin
`ifdef RNS_RECON_FASTMUL_EN
                state_d = ST_RECON;
`else
                if (mul_done) begin
                    state_d = ST_RECON;
                end
`endif
            end
            ST_RECON: begin
`ifdef RNS_RECON_FASTMUL_EN
                state_d = ST_DONE;
`else
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: handshake flags are pure functions of the state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath next values. Output registers only change in CHECK (error)
    // or on the final RECON step, so they stay frozen throughout DONE.
    always_comb begin
        r0_d       = r0_q;
        r1_d       = r1_q;
        tag_d      = tag_q;
        err_d      = err_q;
        out_data_d = out_data_q;
`ifdef RNS_RECON_FASTMUL_EN
        d_d        = d_q;
        k_d        = k_q;
`else
        x_d        = x_q;
        cnt_d      = cnt_q;
        mul_start  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    r0_d  = rns_field(in_res, RNS_R0_LSB);
                    r1_d  = rns_field(in_res, RNS_R1_LSB);
                    tag_d = in_tag;
                    err_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (range_err) begin
                    err_d      = 1'b1;
                    out_data_d = '0;
                end else begin
`ifdef RNS_RECON_FASTMUL_EN
                    d_d       = d_val;
`else
                    mul_start = 1'b1;
                    x_d       = '0;
                    cnt_d     = RNS_TOP_BIT;
`endif
                end
            end
            ST_MODMUL: begin
`ifdef RNS_RECON_FASTMUL_EN
                k_d = 9'(mod_fast);
`endif
            end
            ST_RECON: begin
`ifdef RNS_RECON_FASTMUL_EN
                out_data_d = r0_ext + recon_fast;
`else
                x_d   = x_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_data_d = r0_ext + x_next;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset clears everything, abandoning any
    // conversion in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r0_q       <= '0;
            r1_q       <= '0;
            tag_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
`ifdef RNS_RECON_FASTMUL_EN
            d_q        <= '0;
            k_q        <= '0;
`else
            x_q        <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
`ifdef RNS_RECON_FASTMUL_EN
            d_q        <= d_d;
            k_q        <= k_d;
`else
            x_q        <= x_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign out_data = out_data_q;
    assign out_tag  = tag_q;
    assign out_err  = err_q;

endmodule
